// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the ID/EX stage and its forwarding muxes:
//   - alu_op_e    : 4-bit ALU opcode encoding (add .. sltu)
//   - REG_ZERO    : architectural zero register index (never forwarded)
//   - ctrl_t      : registered control bundle travelling from ID into EX/MEM
//   - CTRL_BUBBLE : control bundle of an inserted bubble (everything off)
//   - gate_ctrl() : forces a control bundle to a bubble when it is not valid
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOR  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // Register index 0 is hard-wired to zero; comparisons against it are
    // resized to the local index width where used.
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An empty decode slot must never carry live control into EX/MEM.
    function automatic ctrl_t gate_ctrl(input ctrl_t c);
        ctrl_t g;
        g = c;
        if (!c.valid) begin
            g = CTRL_BUBBLE;
        end
        return g;
    endfunction

endpackage : mips_pkg

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Priority operand-forwarding mux for one source register.
//   src_i            : registered source register index
//   reg_data_i       : registered register-file read data for that source
//   exm_reg_write_i  : EX/MEM result will be written back
//   exm_rd_i         : EX/MEM destination index
//   exm_result_i     : EX/MEM result value
//   mwb_reg_write_i  : MEM/WB value will be written back
//   mwb_rd_i         : MEM/WB destination index
//   mwb_data_i       : MEM/WB write-back value
//   data_o           : resolved operand value
// The younger producer (EX/MEM) always wins over MEM/WB; register 0 is
// never forwarded because its architectural value is constant zero.
// ---------------------------------------------------------------------------
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              exm_reg_write_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              mwb_reg_write_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic [DATA_W-1:0] mwb_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic src_nonzero;
    logic exm_hit;
    logic mwb_hit;

    always_comb begin
        src_nonzero = (src_i != REG_AW'(REG_ZERO));
        exm_hit     = src_nonzero && exm_reg_write_i && (exm_rd_i == src_i);
        mwb_hit     = src_nonzero && mwb_reg_write_i && (mwb_rd_i == src_i);
    end

    always_comb begin
        if (exm_hit) begin
            data_o = exm_result_i;
        end else if (mwb_hit) begin
            data_o = mwb_data_i;
        end else begin
            data_o = reg_data_i;
        end
    end

endmodule : fwd_mux

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand-forwarding front end for the EX ALU.
//   Inputs from decode (id_*)    : valid, rs/rt data, immediate, rs/rt/rd
//                                  indices, uses_rt, alu_op, alu_src and the
//                                  four control bits.
//   flush                        : squash the decode slot (load a bubble).
//   hold                         : downstream stall, freeze this stage.
//   exm_* / mwb_*                : forwarding sources from EX/MEM and MEM/WB.
//   operand1/operand2/alu_op     : to the ALU.
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd
//                                : registered control consumed downstream.
//   ex_store_data                : forwarded rt value for stores.
//   stall                        : freeze PC and IF/ID this cycle.
//   bubble_count                 : saturating count of load-use bubbles.
// ---------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,

    input  logic              flush,
    input  logic              hold,

    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,

    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [3:0]        alu_op,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_count
);

    // -----------------------------------------------------------------------
    // Pipeline register state
    // -----------------------------------------------------------------------
    ctrl_t             ctrl_q,    ctrl_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [3:0]        alu_op_q,  alu_op_d;
    logic              alu_src_q, alu_src_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              hazard;
    ctrl_t             id_ctrl;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // -----------------------------------------------------------------------
    // Load-use hazard: the load in EX cannot supply its data until MEM, so a
    // dependent instruction in ID must wait one cycle behind a bubble.
    // -----------------------------------------------------------------------
    always_comb begin
        hazard = ctrl_q.valid && ctrl_q.mem_read
              && (rd_q != REG_AW'(REG_ZERO))
              && id_valid
              && ((rd_q == id_rs) || (id_uses_rt && (rd_q == id_rt)));
        // A flush already discards the dependent instruction, and hold
        // freezes everything anyway, so neither needs IF/ID stalled here.
        stall  = hazard && !flush && !hold;
    end

    // -----------------------------------------------------------------------
    // Next-state selection: flush > hold > hazard bubble > capture
    // -----------------------------------------------------------------------
    always_comb begin
        id_ctrl = gate_ctrl('{valid:      id_valid,
                              reg_write:  id_reg_write,
                              mem_read:   id_mem_read,
                              mem_write:  id_mem_write,
                              mem_to_reg: id_mem_to_reg});

        // NOTE: every combinational output is given a default first so no
        // path through the if/else chain leaves one unassigned (no latches).
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        cnt_d     = cnt_q;

        if (flush || (!hold && hazard)) begin
            // Bubble: indices and data are zeroed too, so rs/rt become r0
            // and the operands resolve to 0 without any forwarding.
            ctrl_d    = CTRL_BUBBLE;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            alu_op_d  = ALU_ADD;
            alu_src_d = 1'b0;
            // Only hazard bubbles are counted; a flush bubble is a redirect.
            if (!flush && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!hold) begin
            ctrl_d    = id_ctrl;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            alu_op_d  = id_alu_op;
            alu_src_d = id_alu_src;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_op_q  <= ALU_ADD;
            alu_src_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            cnt_q     <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding on the registered sources; operands settle in the same
    // cycle as the exm_*/mwb_* inputs.
    // -----------------------------------------------------------------------
    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .src_i           (rs_q),
        .reg_data_i      (rs_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_data_i      (mwb_data),
        .data_o          (rs_fwd)
    );

    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .src_i           (rt_q),
        .reg_data_i      (rt_data_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .mwb_data_i      (mwb_data),
        .data_o          (rt_fwd)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        operand1      = rs_fwd;
        ex_store_data = rt_fwd;
        operand2      = alu_src_q ? imm_q : rt_fwd;
        alu_op        = alu_op_q;
        ex_valid      = ctrl_q.valid;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_mem_to_reg = ctrl_q.mem_to_reg;
        ex_rd         = rd_q;
        bubble_count  = cnt_q;
    end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed sequences, a table of
// forwarding vectors, and randomized traffic against a behavioural model of
// the instruction occupying the EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int CW     = 4;   // small counter width so saturation is reachable
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid, id_uses_rt, id_alu_src;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [3:0]    id_alu_op;
    logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic          flush, hold;
    logic          exm_reg_write, mwb_reg_write;
    logic [AW-1:0] exm_rd, mwb_rd;
    logic [DW-1:0] exm_result, mwb_data;
    logic [DW-1:0] operand1, operand2, ex_store_data;
    logic [3:0]    alu_op;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [AW-1:0] ex_rd;
    logic          stall;
    logic [CW-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .hold(hold),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .stall(stall), .bubble_count(bubble_count)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The instruction sitting in EX, as an abstract record.
    typedef struct {
        bit          valid;
        int unsigned rs, rt, rd;
        logic [DW-1:0] rs_data, rt_data, imm;
        int unsigned op;
        bit          use_imm;
        bit          rw, mr, mw, m2r;
    } slot_t;

    slot_t m;
    int    m_bubbles;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{valid: 0, rs: 0, rt: 0, rd: 0, rs_data: '0, rt_data: '0, imm: '0,
              op: 0, use_imm: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
        return s;
    endfunction

    task automatic m_reset();
        m = empty_slot();
        m_bubbles = 0;
    endtask

    // A read of register r sees the youngest in-flight writer, else the file.
    function automatic logic [DW-1:0] value_of(input int unsigned r, input logic [DW-1:0] file_val);
        if (r == 0) return file_val;
        if (exm_reg_write && int'(exm_rd) == int'(r)) return exm_result;
        if (mwb_reg_write && int'(mwb_rd) == int'(r)) return mwb_data;
        return file_val;
    endfunction

    function automatic bit load_use();
        if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 0;
        return (m.rd == id_rs) || (id_uses_rt && m.rd == id_rt);
    endfunction

    // Advance the model and the DUT by one rising edge; returns #1 after it.
    task automatic tick();
        slot_t n;
        n = m;
        if (rst_n) begin
            if (flush) n = empty_slot();
            else if (hold) n = m;
            else if (load_use()) begin
                n = empty_slot();
                if (m_bubbles < CNTMAX) m_bubbles++;
            end else if (id_valid) begin
                n = '{valid: 1, rs: id_rs, rt: id_rt, rd: id_rd, rs_data: id_rs_data,
                      rt_data: id_rt_data, imm: id_imm, op: id_alu_op, use_imm: id_alu_src,
                      rw: id_reg_write, mr: id_mem_read, mw: id_mem_write, m2r: id_mem_to_reg};
            end else begin
                n = '{valid: 0, rs: id_rs, rt: id_rt, rd: id_rd, rs_data: id_rs_data,
                      rt_data: id_rt_data, imm: id_imm, op: id_alu_op, use_imm: id_alu_src,
                      rw: 0, mr: 0, mw: 0, m2r: 0};
            end
        end
        @(posedge clk);
        if (rst_n) m = n;
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] rt_val;
        rt_val = value_of(m.rt, m.rt_data);
        check({tag, ".operand1"},  operand1,      value_of(m.rs, m.rs_data));
        check({tag, ".operand2"},  operand2,      m.use_imm ? m.imm : rt_val);
        check({tag, ".store"},     ex_store_data, rt_val);
        check({tag, ".alu_op"},    DW'(alu_op),   DW'(m.op));
        check({tag, ".ex_valid"},  DW'(ex_valid), DW'(m.valid));
        check({tag, ".reg_write"}, DW'(ex_reg_write),  DW'(m.rw));
        check({tag, ".mem_read"},  DW'(ex_mem_read),   DW'(m.mr));
        check({tag, ".mem_write"}, DW'(ex_mem_write),  DW'(m.mw));
        check({tag, ".mem_to_reg"},DW'(ex_mem_to_reg), DW'(m.m2r));
        check({tag, ".ex_rd"},     DW'(ex_rd),    DW'(m.rd));
        check({tag, ".stall"},     DW'(stall),    DW'(rst_n && load_use() && !flush && !hold));
        check({tag, ".bubbles"},   DW'(bubble_count), DW'(m_bubbles));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_fwd();
        exm_reg_write = 0; exm_rd = '0; exm_result = '0;
        mwb_reg_write = 0; mwb_rd = '0; mwb_data = '0;
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                          input logic [DW-1:0] imm, input int op, input logic src,
                          input logic urt, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_op = 4'(op);
        id_alu_src = src; id_uses_rt = urt; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic put_load(input int rd);
        set_id(1, 1, rd, rd, 32'h100, 32'h0, 32'h4, 0, 1, 0, 1, 1, 0, 1);
        tick();
    endtask

    task automatic put_dep_add(input int rs);
        set_id(1, rs, 2, 3, 32'h1, 32'h2, 32'h0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    // ---------------- forwarding vector table ----------------
    typedef struct {
        logic          ew;  logic [AW-1:0] erd; logic [DW-1:0] eres;
        logic          mw;  logic [AW-1:0] mrd; logic [DW-1:0] mdat;
        logic [DW-1:0] e_op1, e_op2, e_st;
    } fwd_vec_t;

    fwd_vec_t vecs[7];

    initial begin
        // Registered rs=3 (data 0x11), rt=4 (data 0x22), operand2 from rt.
        vecs[0] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  32'h11, 32'h22, 32'h22};
        vecs[1] = '{1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 32'hAA, 32'h22, 32'h22};
        vecs[2] = '{0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 32'hBB, 32'h22, 32'h22};
        vecs[3] = '{1, 5'd4, 32'hCC, 1, 5'd3, 32'hBB, 32'hBB, 32'hCC, 32'hCC};
        vecs[4] = '{1, 5'd4, 32'hCC, 1, 5'd4, 32'hDD, 32'h11, 32'hCC, 32'hCC};
        vecs[5] = '{0, 5'd4, 32'hCC, 1, 5'd4, 32'hDD, 32'h11, 32'hDD, 32'hDD};
        vecs[6] = '{1, 5'd5, 32'hEE, 0, 5'd3, 32'hBB, 32'h11, 32'h22, 32'h22};

        flush = 0; hold = 0;
        clear_fwd();
        set_id(0, 0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();

        // ---- reset state ----
        #12;
        check("reset.ex_valid", DW'(ex_valid), 0);
        check("reset.operand1", operand1, 0);
        check_outputs("reset");
        @(negedge clk); rst_n = 1;

        // ---- plain capture ----
        set_id(1, 1, 2, 3, 32'd5, 32'd7, 32'h0, 1, 0, 1, 1, 0, 0, 0);
        tick();
        check("cap.operand1", operand1, 5);
        check("cap.operand2", operand2, 7);
        check("cap.alu_op",   DW'(alu_op), 1);
        check("cap.ex_valid", DW'(ex_valid), 1);
        check_outputs("cap");

        // ---- forwarding table ----
        set_id(1, 3, 4, 9, 32'h11, 32'h22, 32'h0, 2, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            exm_reg_write = vecs[i].ew; exm_rd = vecs[i].erd; exm_result = vecs[i].eres;
            mwb_reg_write = vecs[i].mw; mwb_rd = vecs[i].mrd; mwb_data   = vecs[i].mdat;
            #1;
            check($sformatf("fwd%0d.operand1", i), operand1,      vecs[i].e_op1);
            check($sformatf("fwd%0d.operand2", i), operand2,      vecs[i].e_op2);
            check($sformatf("fwd%0d.store", i),    ex_store_data, vecs[i].e_st);
        end

        // ---- register 0 is never forwarded ----
        clear_fwd();
        set_id(1, 0, 0, 1, 32'h99, 32'h77, 32'h0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hAA;
        mwb_reg_write = 1; mwb_rd = 0; mwb_data   = 32'hBB;
        #1;
        check("r0.operand1", operand1, 32'h99);
        check("r0.store",    ex_store_data, 32'h77);

        // ---- immediate path ----
        clear_fwd();
        set_id(1, 1, 6, 2, 32'h1, 32'h2, 32'hFFFF_FFFC, 0, 1, 1, 1, 0, 0, 0);
        tick();
        exm_reg_write = 1; exm_rd = 6; exm_result = 32'h55;
        #1;
        check("imm.operand2", operand2, 32'hFFFF_FFFC);
        check("imm.store",    ex_store_data, 32'h55);
        clear_fwd();

        // ---- load-use ----
        put_load(8);
        put_dep_add(8);
        #1;
        check("lu.stall", DW'(stall), 1);
        tick();
        check("lu.ex_valid", DW'(ex_valid), 0);
        check("lu.bubbles",  DW'(bubble_count), 1);
        check("lu.stall_after", DW'(stall), 0);
        check_outputs("lu");
        tick();
        check("lu.dep_captured", DW'(ex_valid), 1);

        put_load(8);
        set_id(1, 1, 8, 3, 32'h1, 32'h2, 32'h0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        check("lu.rt_unused", DW'(stall), 0);
        id_uses_rt = 1; #1;
        check("lu.rt_used", DW'(stall), 1);
        id_valid = 0; #1;
        check("lu.id_invalid", DW'(stall), 0);

        put_load(0);
        put_dep_add(0); #1;
        check("lu.rd0", DW'(stall), 0);

        // ---- flush together with hazard ----
        put_load(8);
        put_dep_add(8); flush = 1; #1;
        check("flush.stall", DW'(stall), 0);
        tick();
        flush = 0;
        check("flush.ex_valid", DW'(ex_valid), 0);
        check("flush.bubbles",  DW'(bubble_count), 1);

        // ---- hold freezes everything for three cycles ----
        put_load(8);
        put_dep_add(8); hold = 1; #1;
        check("hold.stall", DW'(stall), 0);
        for (int i = 0; i < 3; i++) begin
            id_rs_data = $urandom;
            tick();
            check($sformatf("hold%0d.ex_valid", i), DW'(ex_valid), 1);
            check($sformatf("hold%0d.mem_read", i), DW'(ex_mem_read), 1);
            check($sformatf("hold%0d.ex_rd", i),    DW'(ex_rd), 8);
            check($sformatf("hold%0d.operand1", i), operand1, 32'h100);
            check($sformatf("hold%0d.operand2", i), operand2, 32'h4);
            check($sformatf("hold%0d.stall", i),    DW'(stall), 0);
            check($sformatf("hold%0d.bubbles", i),  DW'(bubble_count), 1);
        end
        hold = 0; #1;
        check("hold.release_stall", DW'(stall), 1);
        tick();
        check("hold.release_bubbles", DW'(bubble_count), 2);

        // ---- counter saturation ----
        for (int i = 0; i < CNTMAX + 4; i++) begin
            put_load(9);
            put_dep_add(9);
            tick();
        end
        check("sat.bubbles", DW'(bubble_count), CNTMAX);
        check_outputs("sat");

        // ---- asynchronous reset mid-cycle with a live instruction ----
        set_id(1, 5, 6, 7, 32'h1234, 32'h5678, 32'h0, 3, 0, 1, 1, 0, 0, 0);
        tick();
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'hDEAD;
        #1;
        check("arst.pre_operand1", operand1, 32'hDEAD);
        #2; rst_n = 0; #1;
        m_reset();
        check("arst.ex_valid", DW'(ex_valid), 0);
        check("arst.operand1", operand1, 0);
        check("arst.operand2", operand2, 0);
        check("arst.bubbles",  DW'(bubble_count), 0);
        check_outputs("arst");
        clear_fwd();
        @(negedge clk); rst_n = 1;
        set_id(1, 1, 2, 3, 32'd5, 32'd7, 32'h0, 4, 0, 1, 1, 0, 0, 0);
        tick();
        check("arst.first_capture", DW'(ex_valid), 1);
        check("arst.first_op", DW'(alu_op), 4);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom_range(0, 9),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 15) == 0);
            hold  = ($urandom_range(0, 11) == 0);
            exm_reg_write = 1'($urandom); exm_rd = AW'($urandom_range(0, 7)); exm_result = $urandom;
            mwb_reg_write = 1'($urandom); mwb_rd = AW'($urandom_range(0, 7)); mwb_data   = $urandom;
            #1;
            check_outputs($sformatf("rnd%0d", i));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_id_ex_stage
